// File: rtl/wb_lcd_ctrl.sv
// wb_lcd_ctrl: Wishbone slave that sends bytes to an HD44780 LCD as two 4-bit nibbles with timed E strobes
module wb_lcd_ctrl #(
   parameter int SETUP_CYC = 8,
   parameter int EHIGH_CYC = 50,
   parameter int GAP_CYC   = 100,
   parameter int EXEC_CYC  = 4000,
   parameter int CLEAR_CYC = 160000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        intr,
   output logic [3:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e
);
   typedef enum logic [2:0] {IDLE, SETUP_H, EHIGH_H, GAP, SETUP_L, EHIGH_L, EXEC} state_t;
   // counter holds (cycles - 1) so a state lasts exactly its cycle count
   localparam logic [17:0] LD_SETUP = 18'(SETUP_CYC - 1);
   localparam logic [17:0] LD_EHIGH = 18'(EHIGH_CYC - 1);
   localparam logic [17:0] LD_GAP   = 18'(GAP_CYC - 1);
   localparam logic [17:0] LD_EXEC  = 18'(EXEC_CYC - 1);
   localparam logic [17:0] LD_CLEAR = 18'(CLEAR_CYC - 1);
   state_t      state_q, state_d;
   logic [17:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic [3:0]  lcd_data_q, lcd_data_d;
   logic [31:0] dat_q, dat_d;
   logic        rs_q, rs_d, nib_q, nib_d, clr_q, clr_d;
   logic        ack_q, ack_d, irq_en_q, irq_en_d, nmode_q, nmode_d;
   logic        done_q, done_d, ovr_q, ovr_d;
   logic        bus_req, wr_ack, wr_data, wr_stat, wr_ctrl, busy, accept, set_done;
   logic        long_cmd, unused_ok;
   logic [1:0]  reg_sel;
   logic [17:0] exec_ld;
   assign bus_req   = wb_stb_i & wb_cyc_i;
   assign reg_sel   = wb_adr_i[3:2];
   assign wr_ack    = bus_req & ack_q & wb_we_i;
   assign wr_data   = wr_ack & (reg_sel == 2'd0);
   assign wr_stat   = wr_ack & (reg_sel == 2'd1);
   assign wr_ctrl   = wr_ack & (reg_sel == 2'd2);
   assign busy      = state_q != IDLE;
   assign accept    = wr_data & ~busy;
   assign long_cmd  = ~wb_dat_i[8] & (wb_dat_i[7:2] == 6'd0) & (wb_dat_i[1:0] != 2'd0);
   assign exec_ld   = clr_q ? LD_CLEAR : LD_EXEC;
   assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9], wb_sel_i};
   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign intr      = irq_en_q & done_q;
   assign lcd_data  = lcd_data_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_e     = (state_q == EHIGH_H) | (state_q == EHIGH_L);
   // bus handshake, read mux, control and sticky status bits (hardware set beats W1C)
   always_comb begin
      ack_d    = bus_req & ~ack_q;
      dat_d    = (bus_req & ~ack_q & ~wb_we_i) ?
                 ((reg_sel == 2'd1) ? {29'd0, ovr_q, done_q, busy} :
                  (reg_sel == 2'd2) ? {30'd0, nmode_q, irq_en_q} : 32'd0) : 32'd0;
      irq_en_d = wr_ctrl ? wb_dat_i[0] : irq_en_q;
      nmode_d  = wr_ctrl ? wb_dat_i[1] : nmode_q;
      done_d   = set_done | (done_q & ~(wr_stat & wb_dat_i[1]));
      ovr_d    = (wr_data & busy) | (ovr_q & ~(wr_stat & wb_dat_i[2]));
   end
   // transfer sequencer: each state reloads the down-counter and leaves when it hits zero
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == 18'd0) ? 18'd0 : cnt_q - 18'd1;
      byte_d     = byte_q;
      rs_d       = rs_q;
      nib_d      = nib_q;
      clr_d      = clr_q;
      lcd_data_d = lcd_data_q;
      set_done   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            state_d    = SETUP_H;
            cnt_d      = LD_SETUP;
            byte_d     = wb_dat_i[7:0];
            rs_d       = wb_dat_i[8];
            nib_d      = nmode_q;
            clr_d      = long_cmd;
            lcd_data_d = wb_dat_i[7:4];
         end
         SETUP_H: if (cnt_q == 18'd0) begin
            state_d = EHIGH_H;
            cnt_d   = LD_EHIGH;
         end
         EHIGH_H: if (cnt_q == 18'd0) begin
            state_d = nib_q ? EXEC : GAP;
            cnt_d   = nib_q ? exec_ld : LD_GAP;
         end
         GAP: if (cnt_q == 18'd0) begin
            state_d    = SETUP_L;
            cnt_d      = LD_SETUP;
            lcd_data_d = byte_q[3:0];
         end
         SETUP_L: if (cnt_q == 18'd0) begin
            state_d = EHIGH_L;
            cnt_d   = LD_EHIGH;
         end
         EHIGH_L: if (cnt_q == 18'd0) begin
            state_d = EXEC;
            cnt_d   = exec_ld;
         end
         EXEC: if (cnt_q == 18'd0) begin
            state_d  = IDLE;
            set_done = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and register flops; reset aborts any transfer at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         byte_q     <= '0;
         rs_q       <= 1'b0;
         nib_q      <= 1'b0;
         clr_q      <= 1'b0;
         lcd_data_q <= '0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         irq_en_q   <= 1'b0;
         nmode_q    <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_q     <= byte_d;
         rs_q       <= rs_d;
         nib_q      <= nib_d;
         clr_q      <= clr_d;
         lcd_data_q <= lcd_data_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         irq_en_q   <= irq_en_d;
         nmode_q    <= nmode_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
      end
   end
endmodule

// File: tb/tb_wb_lcd_ctrl.sv
// tb_wb_lcd_ctrl: scoreboard bench for wb_lcd_ctrl (reads, E pulses and busy lengths checked by a monitor)
module tb_wb_lcd_ctrl;
   localparam int CLR    = 12000;
   localparam int T_FULL = 8 + 50 + 100 + 8 + 50 + 4000;
   localparam int T_CLR  = 8 + 50 + 100 + 8 + 50 + CLR;
   localparam int T_NIB  = 8 + 50 + 4000;
   typedef struct {logic [3:0] d; logic rs; int w;} pulse_t;
   logic        clk = 0, reset = 0;
   logic [31:0] wb_adr_i = 0, wb_dat_i = 0, wb_dat_o;
   logic        wb_stb_i = 0, wb_cyc_i = 0, wb_we_i = 0, wb_ack_o, intr;
   logic [3:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_e;
   int          checks = 0, fails = 0, cyc = 0;
   logic [31:0] rd_q[$];
   pulse_t      pul_q[$];
   int          busy_q[$];
   pulse_t      cur;
   logic        e_on = 0, e_bad = 0, st_valid = 0, intr_p = 0;
   int          e_w = 0, st = 0;

   wb_lcd_ctrl #(.CLEAR_CYC(CLR)) dut (
      .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(4'hf), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
      .wb_ack_o(wb_ack_o), .intr(intr), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_e(lcd_e)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: pops expectations whenever the DUT acks a read, raises E, or raises intr
   always @(negedge clk) begin
      if (!reset) begin
         e_on = 0;
         st_valid = 0;
         intr_p = 0;
      end else begin
         if (wb_ack_o && !wb_we_i) begin
            check("read_pending", 32'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) check("read_data", wb_dat_o, rd_q.pop_front());
         end
         if (wb_ack_o && wb_we_i && wb_adr_i[3:2] == 2'd0 && !st_valid) begin
            st_valid = 1;
            st = cyc + 1;
         end
         if (lcd_e && !e_on) begin
            e_on = 1;
            e_w = 1;
            e_bad = 0;
            check("pulse_pending", 32'(pul_q.size() > 0), 1);
            cur = (pul_q.size() > 0) ? pul_q.pop_front() : '{4'hx, 1'bx, 0};
            check("pulse_data", 32'(lcd_data), 32'(cur.d));
            check("pulse_rs", 32'(lcd_rs), 32'(cur.rs));
         end else if (lcd_e) begin
            e_w++;
            if (lcd_data !== cur.d || lcd_rs !== cur.rs) e_bad = 1;
         end else if (e_on) begin
            e_on = 0;
            if (cur.w != 0) check("pulse_width", e_w, cur.w);
            check("pulse_hold", 32'(e_bad), 0);
         end
         check("lcd_rw", 32'(lcd_rw), 0);
         if (intr && !intr_p) begin
            check("busy_pending", 32'(st_valid && busy_q.size() > 0), 1);
            if (st_valid && busy_q.size() > 0) check("busy_len", cyc - st, busy_q.pop_front());
            st_valid = 0;
         end
         intr_p = intr;
      end
   end

   task automatic wb_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      int n = 0;
      @(negedge clk);
      wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
      do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
      check("ack", 32'(wb_ack_o), 1);
      @(posedge clk);
      #1 wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
   endtask

   task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
      wb_acc(1, adr, dat);
   endtask

   task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp);
      rd_q.push_back(exp);
      wb_acc(0, adr, 0);
   endtask

   task automatic wait_sig(input string nm, input int which, input logic val, input int max);
      int n = 0;
      while (((which == 0) ? intr : lcd_e) !== val && n < max) begin @(negedge clk); n++; end
      check(nm, 32'((which == 0) ? intr : lcd_e), 32'(val));
   endtask

   task automatic xfer(input logic [8:0] v, input int len, input logic [31:0] stat);
      pul_q.push_back('{v[7:4], v[8], 50});
      pul_q.push_back('{v[3:0], v[8], 50});
      busy_q.push_back(len);
      wb_wr(0, 32'(v));
      wait_sig("intr_rise", 0, 1, len + 100);
      wb_rd(4, stat);
      wb_wr(4, 32'h6);
      check("intr_cleared", 32'(intr), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   initial begin
      repeat (5) @(negedge clk);
      check("rst_e", 32'(lcd_e), 0);
      reset = 1;
      @(negedge clk);
      check("rst_ack", 32'(wb_ack_o), 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_intr", 32'(intr), 0);
      check("rst_lcd", {lcd_data, lcd_rs, lcd_e}, 0);
      wb_rd(4, 0);
      wb_rd(8, 0);
      wb_wr(8, 1);
      wb_rd(8, 1);
      wb_wr(12, 32'hffff_ffff);
      wb_rd(12, 0);
      wb_rd(0, 0);
      // 'A' as data: two 50-cycle pulses 0x4 then 0x1
      xfer(9'h141, T_FULL, 2);
      check("hold_data", {28'd0, lcd_data}, 1);
      check("hold_rs", 32'(lcd_rs), 1);
      wb_rd(4, 0);
      // clear and home use the long wait; same bytes with rs=1 do not
      xfer(9'h001, T_CLR, 2);
      xfer(9'h101, T_FULL, 2);
      xfer(9'h003, T_CLR, 2);
      // overrun: second write dropped, first transfer unchanged
      pul_q.push_back('{4'h4, 1'b1, 50});
      pul_q.push_back('{4'h1, 1'b1, 50});
      busy_q.push_back(T_FULL);
      wb_wr(0, 32'h141);
      repeat (20) @(negedge clk);
      wb_wr(0, 32'h142);
      wb_rd(4, 5);
      wait_sig("intr_rise_ovr", 0, 1, T_FULL + 100);
      wb_rd(4, 6);
      repeat (200) @(negedge clk);
      wb_rd(4, 6);
      wb_wr(4, 4);
      wb_rd(4, 2);
      wb_wr(4, 2);
      wb_rd(4, 0);
      // nibble mode: single pulse; CTRL change mid-transfer applies to the next one
      wb_wr(8, 3);
      pul_q.push_back('{4'h3, 1'b0, 50});
      busy_q.push_back(T_NIB);
      wb_wr(0, 32'h030);
      wb_wr(8, 1);
      wb_rd(8, 1);
      wait_sig("intr_rise_nib", 0, 1, T_NIB + 100);
      wb_rd(4, 2);
      check("nib_data", {28'd0, lcd_data}, 3);
      wb_wr(4, 2);
      // reset during the second E pulse
      pul_q.push_back('{4'h4, 1'b1, 50});
      pul_q.push_back('{4'h1, 1'b1, 0});
      wb_wr(0, 32'h141);
      wait_sig("e_first", 1, 1, 100);
      wait_sig("e_first_fall", 1, 0, 100);
      wait_sig("e_second", 1, 1, 300);
      repeat (10) @(negedge clk);
      #2 reset = 0;
      #1 check("abort_e", 32'(lcd_e), 0);
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      check("post_rst_intr", 32'(intr), 0);
      check("post_rst_lcd", {lcd_data, lcd_rs}, 0);
      wb_rd(4, 0);
      wb_rd(8, 0);
      wb_wr(8, 1);
      xfer(9'h141, T_FULL, 2);
      repeat (5) @(negedge clk);
      check("pulses_left", pul_q.size(), 0);
      check("busy_left", busy_q.size(), 0);
      check("reads_left", rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
